// File: rtl/hilo_mdu_scheduler.sv
// hilo_mdu_scheduler: HI/LO register pair with multi-cycle MULT/DIV sequencing and decode stall.
// Ports:
//   clk, reset (async, active-high)
//   start, op[2:0], rs_val, rt_val : issue from decode (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   flush                          : abort the in-flight MULT/DIV, HI/LO untouched
//   hilo_rd_req                    : decode reads HI or LO as operand 2 this cycle
//   in_ready, busy, stall, done    : handshake, in-flight flag, decode hold, commit pulse
//   hi_out, lo_out                 : HI/LO to the operand-2 mux
// Optional feature macro HILO_FWD_EN: forward the pending result during the last busy cycle.
module hilo_mdu_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        hilo_rd_req,
    output logic        in_ready,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    localparam int MAXL = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAXL) + 1;
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [31:0]   a_q, b_q, hi, lo;
    logic          accept, last, sgn;
    logic [63:0]   prod;
    logic [31:0]   ma, mb, q, r, res_hi, res_lo;

    assign busy     = state == BUSY;
    assign in_ready = !busy;
    assign accept   = start & in_ready & !flush;
    assign last     = busy & (cnt == '0) & !flush;
    assign sgn      = !op_q[0];

    // One shared multiplier: sign-extend for MULT, zero-extend for MULTU.
    // Division works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    always_comb begin
        prod   = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
        ma     = (sgn & a_q[31]) ? -a_q : a_q;
        mb     = (sgn & b_q[31]) ? -b_q : b_q;
        q      = (mb == '0) ? '1 : ma / mb;
        r      = (mb == '0) ? ma : ma % mb;
        res_lo = !op_q[1] ? prod[31:0]  : (b_q == '0) ? '1  : (sgn & (a_q[31] ^ b_q[31])) ? -q : q;
        res_hi = !op_q[1] ? prod[63:32] : (b_q == '0) ? a_q : (sgn & a_q[31]) ? -r : r;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (accept & !op[2]) ? BUSY : IDLE;
        else if (flush || cnt == '0)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (accept & !op[2]) begin
                cnt  <= op[1] ? DIV_INIT : MUL_INIT;
                op_q <= op[1:0];
                a_q  <= rs_val;
                b_q  <= rt_val;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (accept && op == 3'b100)
                hi <= rs_val;
            if (accept && op == 3'b101)
                lo <= rs_val;
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

`ifdef HILO_FWD_EN
    assign hi_out = last ? res_hi : hi;
    assign lo_out = last ? res_lo : lo;
    assign stall  = busy & (start | (hilo_rd_req & !last));
`else
    assign hi_out = hi;
    assign lo_out = lo;
    assign stall  = busy & (start | hilo_rd_req);
`endif
endmodule

// File: tb/tb_hilo_mdu_scheduler.sv
// tb_hilo_mdu_scheduler: scoreboard bench for hilo_mdu_scheduler with directed vectors.
module tb_hilo_mdu_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        hilo_rd_req = 1'b0;
    logic        in_ready, busy, stall, done;
    logic [31:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;
    int ndone = 0;
    int ndone_exp = 0;
    logic [63:0] sb[$];
    logic [63:0] model = '0;

    hilo_mdu_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .flush(flush), .hilo_rd_req(hilo_rd_req), .in_ready(in_ready), .busy(busy),
        .stall(stall), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done with hilo %h expected no done", {hi_out, lo_out});
            end else begin
                chk("hilo_commit", {hi_out, lo_out}, sb.pop_front());
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int lat);
        int n = 0;
        sb.push_back(e);
        ndone_exp++;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("busy_cycles", 64'(n), 64'(lat));
        model = e;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", {60'b0, in_ready, busy, done, stall}, 64'b1000);
        chk("reset_hilo", {hi_out, lo_out}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA, 4);
        run_op(3'b001, 32'hFFFFFFFE, 32'h3, 64'h00000002_FFFFFFFA, 4);
        run_op(3'b010, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 12);
        run_op(3'b011, 32'h7, 32'h0, 64'h00000007_FFFFFFFF, 12);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 12);
        run_op(3'b010, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 12);
        run_op(3'b010, 32'hFFFFFFF9, 32'h0, 64'hFFFFFFF9_FFFFFFFF, 12);

        // Dependent read held through a MULT, plus an ignored start in busy cycle 2.
        begin
            int n = 0;
            int ns = 0;
            hilo_rd_req = 1'b1;
            sb.push_back(64'h00000001_00000000);
            ndone_exp++;
            start = 1'b1; op = 3'b000; rs_val = 32'h00010000; rt_val = 32'h00010000;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!busy) break;
                n++;
                if (stall) ns++;
                if (start) chk("busy_start_ctl", {62'b0, in_ready, stall}, 64'b01);
`ifdef HILO_FWD_EN
                if (n == 4) chk("last_cycle_view", {hi_out, lo_out}, 64'h00000001_00000000);
`else
                if (n == 4) chk("last_cycle_view", {hi_out, lo_out}, model);
`endif
                @(posedge clk); #1;
                start = (n == 1);
                op = 3'b001; rs_val = 32'h1; rt_val = 32'h1;
            end
            start = 1'b0;
            hilo_rd_req = 1'b0;
            chk("stall_busy_cycles", 64'(n), 64'd4);
`ifdef HILO_FWD_EN
            chk("stall_count", 64'(ns), 64'd3);
`else
            chk("stall_count", 64'(ns), 64'd4);
`endif
            model = 64'h00000001_00000000;
        end

        // Back-to-back MTHI then MTLO.
        start = 1'b1; op = 3'b100; rs_val = 32'h12345678;
        @(posedge clk); #1;
        op = 3'b101; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        chk("mthi", {hi_out, 31'b0, busy}, {32'h12345678, 32'h0});
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("mtlo", {hi_out, lo_out}, 64'h12345678_9ABCDEF0);
        chk("mt_busy", {63'b0, busy}, 64'h0);
        model = 64'h12345678_9ABCDEF0;

        // Reserved op is a no-op.
        start = 1'b1; op = 3'b110; rs_val = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("reserved_op", {hi_out, lo_out}, model);
        chk("reserved_busy", {63'b0, busy}, 64'h0);

        // DIV flushed in busy cycle 5.
        start = 1'b1; op = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", {63'b0, busy}, 64'h1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {62'b0, busy, in_ready}, 64'b01);
        chk("flush_hilo", {hi_out, lo_out}, model);
        repeat (15) @(negedge clk);

        // flush together with start in IDLE drops the start.
        start = 1'b1; flush = 1'b1; op = 3'b100; rs_val = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_drops_start", {hi_out, lo_out}, model);

        // Reset in cycle 3 of a MULT.
        start = 1'b1; op = 3'b000; rs_val = 32'd5; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_ctl", {62'b0, busy, in_ready}, 64'b01);
        chk("reset_mid_hilo", {hi_out, lo_out}, 64'h0);
        #2 reset = 1'b0;
        model = '0;
        @(negedge clk);
        run_op(3'b001, 32'd5, 32'd7, 64'h00000000_00000023, 4);

        repeat (20) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(ndone), 64'(ndone_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
